// File: rtl/nou_bu_pkg.sv
// Shared types, field widths, error codes and slot-search helpers for the NOU buffer-pool manager.
package nou_bu_pkg;

  localparam int unsigned NOU_SID_WIDTH           = 8;
  localparam int unsigned NOU_OP_TYPE_WIDTH       = 2;
  localparam int unsigned NOU_BUF_ID_WIDTH        = 8;
  localparam int unsigned NOU_BUF_ADDR_WIDTH      = 16;
  localparam int unsigned NOU_BUF_SIZE_WIDTH      = 8;
  localparam int unsigned NOU_RM_WIDTH            = 1;
  localparam int unsigned NOU_PKT_HDR_SZ_WIDTH    = 16;
  localparam int unsigned NOU_PKT_DATA_SZ_WIDTH   = 16;
  localparam int unsigned NOU_PKT_HDR_ADDR_WIDTH  = 16;
  localparam int unsigned NOU_PKT_DATA_ADDR_WIDTH = 16;
  localparam int unsigned NOU_ERR_CODE_WIDTH      = 3;

  localparam logic NOU_STATUS_OK  = 1'b0;
  localparam logic NOU_STATUS_ERR = 1'b1;

  localparam logic [NOU_ERR_CODE_WIDTH-1:0] NOU_ERR_NONE   = 3'd0;
  localparam logic [NOU_ERR_CODE_WIDTH-1:0] NOU_ERR_NO_BUF = 3'd1;
  localparam logic [NOU_ERR_CODE_WIDTH-1:0] NOU_ERR_STATE  = 3'd2;
  localparam logic [NOU_ERR_CODE_WIDTH-1:0] NOU_ERR_ID     = 3'd3;
  localparam logic [NOU_ERR_CODE_WIDTH-1:0] NOU_ERR_OP     = 3'd4;

  typedef enum logic [1:0] {
    SLOT_EMPTY    = 2'd0,
    SLOT_GRANTED  = 2'd1,
    SLOT_ASSIGNED = 2'd2
  } slot_status_e;

  typedef enum logic [NOU_OP_TYPE_WIDTH-1:0] {
    BU_OP_GRANT   = 2'd0,
    BU_OP_REVOKE  = 2'd1,
    BU_OP_RELEASE = 2'd2
  } bu_op_e;

  typedef struct packed {
    logic [NOU_SID_WIDTH-1:0]      sid;
    logic [NOU_OP_TYPE_WIDTH-1:0]  rtype;
    logic [NOU_BUF_ID_WIDTH-1:0]   buf_id;
    logic                          status;
    logic [NOU_ERR_CODE_WIDTH-1:0] err;
    logic [NOU_RM_WIDTH-1:0]       rm;
  } bu_rsp_t;

  // Search helpers cover the largest legal table; result is {found, index}.
  localparam int unsigned FIND_W = 256;

  function automatic logic [8:0] find_first_one_index_forward(input logic [FIND_W-1:0] vec);
    logic [8:0] res;
    res = '0;
    for (int unsigned i = FIND_W; i > 0; i--) begin
      if (vec[i-1]) res = {1'b1, 8'(i - 1)};
    end
    return res;
  endfunction

  function automatic logic [8:0] find_first_one_index_backward(input logic [FIND_W-1:0] vec);
    logic [8:0] res;
    res = '0;
    for (int unsigned i = 0; i < FIND_W; i++) begin
      if (vec[i]) res = {1'b1, 8'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/nou_bu_rsp_fifo.sv
// Retire-response FIFO: wrap-around read/write pointers plus an occupancy count.
module nou_bu_rsp_fifo
  import nou_bu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    push,
  input  bu_rsp_t push_data,
  input  logic    pop,
  output bu_rsp_t head,
  output logic    empty,
  output logic    full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bu_rsp_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nou_bu_pool.sv
// NOU receive buffer-pool manager: slot table driven by BRR commands, header/data
// slot allocation for RPU requests, and a backpressured BURR retire queue.
module nou_bu_pool
  import nou_bu_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 32,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter int unsigned HDR_MIN_KB = 1,
  parameter int unsigned PRESET_EN  = 1,
  parameter int unsigned HDR_BASE   = 'h500,
  parameter int unsigned DATA_BASE  = 'h520,
  parameter int unsigned HDR_KB     = 2,
  parameter int unsigned DATA_KB    = 32
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               brr_bu_vld,
  output logic                               brr_bu_rdy,
  input  logic [NOU_SID_WIDTH-1:0]           brr_bu_sid,
  input  logic [NOU_OP_TYPE_WIDTH-1:0]       brr_bu_op_type,
  input  logic [NOU_BUF_ID_WIDTH-1:0]        brr_bu_buf_id,
  input  logic [NOU_BUF_ADDR_WIDTH-1:0]      brr_bu_buf_addr,
  input  logic [NOU_BUF_SIZE_WIDTH-1:0]      brr_bu_buf_size,
  input  logic [NOU_RM_WIDTH-1:0]            brr_bu_rm,
  input  logic                               rpu_bu_req_buf_vld,
  input  logic [NOU_PKT_HDR_SZ_WIDTH-1:0]    rpu_bu_req_buf_header_size,
  input  logic [NOU_PKT_DATA_SZ_WIDTH-1:0]   rpu_bu_req_buf_data_size,
  output logic                               bu_rpu_gnt_buf_vld,
  output logic                               bu_rpu_gnt_buf_status,
  output logic [NOU_PKT_HDR_ADDR_WIDTH-1:0]  bu_rpu_header_buf_addr,
  output logic [NOU_PKT_DATA_ADDR_WIDTH-1:0] bu_rpu_data_buf_addr,
  output logic [NOU_ERR_CODE_WIDTH-1:0]      bu_rpu_gnt_buf_err_code,
  input  logic                               retire_burr_keep,
  output logic                               burr_retire_vld,
  output logic [NOU_SID_WIDTH-1:0]           burr_retire_sid,
  output logic [NOU_OP_TYPE_WIDTH-1:0]       burr_retire_rsp_type,
  output logic [NOU_BUF_ID_WIDTH-1:0]        burr_retire_buf_id,
  output logic                               burr_retire_status,
  output logic [NOU_ERR_CODE_WIDTH-1:0]      burr_retire_err_code,
  output logic [NOU_RM_WIDTH-1:0]            burr_retire_rm
);

  localparam int unsigned ID_W   = $clog2(NUM_SLOTS);
  localparam int unsigned SIZE_W = NOU_BUF_SIZE_WIDTH;

  slot_status_e                  slot_st   [NUM_SLOTS];
  logic [NOU_BUF_ADDR_WIDTH-1:0] slot_addr [NUM_SLOTS];
  logic [SIZE_W-1:0]             slot_size [NUM_SLOTS];

  logic [NUM_SLOTS-1:0]          hdr_vld;
  logic [NUM_SLOTS-1:0]          data_vld;
  logic [SIZE_W:0]               need_kb;
  logic [8:0]                    hdr_find;
  logic [8:0]                    data_find;
  logic [ID_W-1:0]               hdr_idx;
  logic [ID_W-1:0]               data_idx;
  logic                          alloc_ok;
  logic                          cmd_acc;
  logic                          cmd_in_range;
  logic [ID_W-1:0]               cmd_idx;
  logic [NOU_ERR_CODE_WIDTH-1:0] cmd_err;
  bu_rsp_t                       cmd_rsp;
  bu_rsp_t                       fifo_head;
  bu_rsp_t                       ret_out;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic                          unused_bits;

  assign unused_bits = ^{rpu_bu_req_buf_header_size, hdr_find, data_find};

  always_comb begin
    need_kb = (SIZE_W+1)'((17'(rpu_bu_req_buf_data_size) + 17'd1023) >> 10);
    hdr_vld  = '0;
    data_vld = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      hdr_vld[i]  = (slot_st[i] == SLOT_GRANTED) && (slot_size[i] >= SIZE_W'(HDR_MIN_KB));
      data_vld[i] = (slot_st[i] == SLOT_GRANTED) && ({1'b0, slot_size[i]} >= need_kb);
    end
  end

  assign hdr_find  = find_first_one_index_forward(FIND_W'(hdr_vld));
  assign data_find = find_first_one_index_backward(FIND_W'(data_vld));
  assign hdr_idx   = hdr_find[ID_W-1:0];
  assign data_idx  = data_find[ID_W-1:0];
  assign alloc_ok  = rpu_bu_req_buf_vld & hdr_find[8] & data_find[8] & (hdr_idx != data_idx);

  assign brr_bu_rdy   = ~fifo_full;
  assign cmd_acc      = brr_bu_vld & brr_bu_rdy;
  assign cmd_in_range = {1'b0, brr_bu_buf_id} < (NOU_BUF_ID_WIDTH+1)'(NUM_SLOTS);
  assign cmd_idx      = brr_bu_buf_id[ID_W-1:0];

  always_comb begin
    cmd_err = NOU_ERR_NONE;
    if (!cmd_in_range) begin
      cmd_err = NOU_ERR_ID;
    end else begin
      case (bu_op_e'(brr_bu_op_type))
        BU_OP_GRANT:
          if (slot_st[cmd_idx] != SLOT_EMPTY || brr_bu_buf_size == '0) cmd_err = NOU_ERR_STATE;
        BU_OP_REVOKE:
          if (slot_st[cmd_idx] != SLOT_GRANTED) cmd_err = NOU_ERR_STATE;
        BU_OP_RELEASE:
          if (slot_st[cmd_idx] != SLOT_ASSIGNED) cmd_err = NOU_ERR_STATE;
        default: cmd_err = NOU_ERR_OP;
      endcase
      // A slot being handed to the RPU this cycle is off limits to BRR.
      if (cmd_err == NOU_ERR_NONE && alloc_ok && (cmd_idx == hdr_idx || cmd_idx == data_idx))
        cmd_err = NOU_ERR_STATE;
    end
  end

  always_comb begin
    cmd_rsp.sid    = brr_bu_sid;
    cmd_rsp.rtype  = brr_bu_op_type;
    cmd_rsp.buf_id = brr_bu_buf_id;
    cmd_rsp.status = (cmd_err == NOU_ERR_NONE) ? NOU_STATUS_OK : NOU_STATUS_ERR;
    cmd_rsp.err    = cmd_err;
    cmd_rsp.rm     = brr_bu_rm;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (PRESET_EN == 0) begin
          slot_st[i]   <= SLOT_EMPTY;
          slot_addr[i] <= '0;
          slot_size[i] <= '0;
        end else if (i < NUM_SLOTS / 2) begin
          slot_st[i]   <= SLOT_GRANTED;
          slot_addr[i] <= NOU_BUF_ADDR_WIDTH'(HDR_BASE + i * HDR_KB);
          slot_size[i] <= SIZE_W'(HDR_KB);
        end else begin
          slot_st[i]   <= SLOT_GRANTED;
          slot_addr[i] <= NOU_BUF_ADDR_WIDTH'(DATA_BASE + (i - NUM_SLOTS / 2) * DATA_KB);
          slot_size[i] <= SIZE_W'(DATA_KB);
        end
      end
    end else begin
      if (alloc_ok) begin
        slot_st[hdr_idx]  <= SLOT_ASSIGNED;
        slot_st[data_idx] <= SLOT_ASSIGNED;
      end
      if (cmd_acc && cmd_err == NOU_ERR_NONE) begin
        case (bu_op_e'(brr_bu_op_type))
          BU_OP_GRANT: begin
            slot_st[cmd_idx]   <= SLOT_GRANTED;
            slot_addr[cmd_idx] <= brr_bu_buf_addr;
            slot_size[cmd_idx] <= brr_bu_buf_size;
          end
          BU_OP_REVOKE:  slot_st[cmd_idx] <= SLOT_EMPTY;
          BU_OP_RELEASE: slot_st[cmd_idx] <= SLOT_GRANTED;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bu_rpu_gnt_buf_vld      <= 1'b0;
      bu_rpu_gnt_buf_status   <= 1'b0;
      bu_rpu_header_buf_addr  <= '0;
      bu_rpu_data_buf_addr    <= '0;
      bu_rpu_gnt_buf_err_code <= '0;
    end else begin
      bu_rpu_gnt_buf_vld      <= rpu_bu_req_buf_vld;
      bu_rpu_gnt_buf_status   <= 1'b0;
      bu_rpu_header_buf_addr  <= '0;
      bu_rpu_data_buf_addr    <= '0;
      bu_rpu_gnt_buf_err_code <= '0;
      if (rpu_bu_req_buf_vld) begin
        if (alloc_ok) begin
          bu_rpu_gnt_buf_status  <= NOU_STATUS_OK;
          bu_rpu_header_buf_addr <= slot_addr[hdr_idx];
          bu_rpu_data_buf_addr   <= slot_addr[data_idx];
        end else begin
          bu_rpu_gnt_buf_status   <= NOU_STATUS_ERR;
          bu_rpu_gnt_buf_err_code <= NOU_ERR_NO_BUF;
        end
      end
    end
  end

  nou_bu_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cmd_acc),
    .push_data (cmd_rsp),
    .pop       (~retire_burr_keep),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign ret_out              = fifo_empty ? '0 : fifo_head;
  assign burr_retire_vld      = ~fifo_empty;
  assign burr_retire_sid      = ret_out.sid;
  assign burr_retire_rsp_type = ret_out.rtype;
  assign burr_retire_buf_id   = ret_out.buf_id;
  assign burr_retire_status   = ret_out.status;
  assign burr_retire_err_code = ret_out.err;
  assign burr_retire_rm       = ret_out.rm;

endmodule

// File: tb/tb_nou_bu_pool.sv
// Scoreboard bench for nou_bu_pool: expected grants/retires queued at stimulus time, checked on output.
module tb_nou_bu_pool;
  import nou_bu_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                               brr_bu_vld;
  logic                               brr_bu_rdy;
  logic [NOU_SID_WIDTH-1:0]           brr_bu_sid;
  logic [NOU_OP_TYPE_WIDTH-1:0]       brr_bu_op_type;
  logic [NOU_BUF_ID_WIDTH-1:0]        brr_bu_buf_id;
  logic [NOU_BUF_ADDR_WIDTH-1:0]      brr_bu_buf_addr;
  logic [NOU_BUF_SIZE_WIDTH-1:0]      brr_bu_buf_size;
  logic [NOU_RM_WIDTH-1:0]            brr_bu_rm;
  logic                               rpu_bu_req_buf_vld;
  logic [NOU_PKT_HDR_SZ_WIDTH-1:0]    rpu_bu_req_buf_header_size;
  logic [NOU_PKT_DATA_SZ_WIDTH-1:0]   rpu_bu_req_buf_data_size;
  logic                               bu_rpu_gnt_buf_vld;
  logic                               bu_rpu_gnt_buf_status;
  logic [NOU_PKT_HDR_ADDR_WIDTH-1:0]  bu_rpu_header_buf_addr;
  logic [NOU_PKT_DATA_ADDR_WIDTH-1:0] bu_rpu_data_buf_addr;
  logic [NOU_ERR_CODE_WIDTH-1:0]      bu_rpu_gnt_buf_err_code;
  logic                               retire_burr_keep;
  logic                               burr_retire_vld;
  logic [NOU_SID_WIDTH-1:0]           burr_retire_sid;
  logic [NOU_OP_TYPE_WIDTH-1:0]       burr_retire_rsp_type;
  logic [NOU_BUF_ID_WIDTH-1:0]        burr_retire_buf_id;
  logic                               burr_retire_status;
  logic [NOU_ERR_CODE_WIDTH-1:0]      burr_retire_err_code;
  logic [NOU_RM_WIDTH-1:0]            burr_retire_rm;

  nou_bu_pool #(
    .NUM_SLOTS  (32),
    .RSP_DEPTH  (4),
    .HDR_MIN_KB (1),
    .PRESET_EN  (1)
  ) dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .brr_bu_vld                 (brr_bu_vld),
    .brr_bu_rdy                 (brr_bu_rdy),
    .brr_bu_sid                 (brr_bu_sid),
    .brr_bu_op_type             (brr_bu_op_type),
    .brr_bu_buf_id              (brr_bu_buf_id),
    .brr_bu_buf_addr            (brr_bu_buf_addr),
    .brr_bu_buf_size            (brr_bu_buf_size),
    .brr_bu_rm                  (brr_bu_rm),
    .rpu_bu_req_buf_vld         (rpu_bu_req_buf_vld),
    .rpu_bu_req_buf_header_size (rpu_bu_req_buf_header_size),
    .rpu_bu_req_buf_data_size   (rpu_bu_req_buf_data_size),
    .bu_rpu_gnt_buf_vld         (bu_rpu_gnt_buf_vld),
    .bu_rpu_gnt_buf_status      (bu_rpu_gnt_buf_status),
    .bu_rpu_header_buf_addr     (bu_rpu_header_buf_addr),
    .bu_rpu_data_buf_addr       (bu_rpu_data_buf_addr),
    .bu_rpu_gnt_buf_err_code    (bu_rpu_gnt_buf_err_code),
    .retire_burr_keep           (retire_burr_keep),
    .burr_retire_vld            (burr_retire_vld),
    .burr_retire_sid            (burr_retire_sid),
    .burr_retire_rsp_type       (burr_retire_rsp_type),
    .burr_retire_buf_id         (burr_retire_buf_id),
    .burr_retire_status         (burr_retire_status),
    .burr_retire_err_code       (burr_retire_err_code),
    .burr_retire_rm             (burr_retire_rm)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [63:0] gnt_q [$];
  logic [63:0] ret_q [$];
  logic [7:0]  sid_ctr = 8'h10;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] gnt_exp(input logic st, input int err, input int hdr, input int dat);
    return 64'({st, 3'(err), 16'(hdr), 16'(dat)});
  endfunction

  function automatic logic [63:0] ret_exp(input logic [7:0] sid, input logic [1:0] op,
                                          input int id, input int err, input logic rm);
    logic st;
    st = (err == 0) ? NOU_STATUS_OK : NOU_STATUS_ERR;
    return 64'({sid, op, 8'(id), st, 3'(err), rm});
  endfunction

  function automatic logic [63:0] gnt_obs();
    return 64'({bu_rpu_gnt_buf_status, bu_rpu_gnt_buf_err_code,
                bu_rpu_header_buf_addr, bu_rpu_data_buf_addr});
  endfunction

  function automatic logic [63:0] ret_obs();
    return 64'({burr_retire_sid, burr_retire_rsp_type, burr_retire_buf_id,
                burr_retire_status, burr_retire_err_code, burr_retire_rm});
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (bu_rpu_gnt_buf_vld) begin
        if (gnt_q.size() == 0) check_val("gnt_unexpected", 64'(bu_rpu_gnt_buf_vld), 0);
        else check_val("gnt", gnt_obs(), gnt_q.pop_front());
      end
      if (burr_retire_vld) begin
        if (ret_q.size() == 0) check_val("retire_unexpected", 64'(burr_retire_vld), 0);
        else begin
          check_val("retire", ret_obs(), ret_q[0]);
          if (!retire_burr_keep) void'(ret_q.pop_front());
        end
      end
    end
  end

  task automatic brr_cmd(input logic [1:0] op, input int id, input int addr, input int size, input int err);
    int unsigned n;
    n = 0;
    brr_bu_vld      = 1'b1;
    brr_bu_sid      = sid_ctr;
    brr_bu_op_type  = op;
    brr_bu_buf_id   = 8'(id);
    brr_bu_buf_addr = 16'(addr);
    brr_bu_buf_size = 8'(size);
    brr_bu_rm       = sid_ctr[0];
    while (!brr_bu_rdy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!brr_bu_rdy) begin
      check_val("brr_rdy_timeout", 64'(brr_bu_rdy), 1);
      brr_bu_vld = 1'b0;
      return;
    end
    ret_q.push_back(ret_exp(sid_ctr, op, id, err, sid_ctr[0]));
    @(posedge clk); #1;
    brr_bu_vld = 1'b0;
    sid_ctr++;
  endtask

  task automatic rpu_req(input int data_size, input logic [63:0] exp);
    rpu_bu_req_buf_vld         = 1'b1;
    rpu_bu_req_buf_header_size = 16'd64;
    rpu_bu_req_buf_data_size   = 16'(data_size);
    gnt_q.push_back(exp);
    @(posedge clk); #1;
    rpu_bu_req_buf_vld = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n;
    brr_bu_vld = 1'b0;
    brr_bu_sid = '0;
    brr_bu_op_type = '0;
    brr_bu_buf_id = '0;
    brr_bu_buf_addr = '0;
    brr_bu_buf_size = '0;
    brr_bu_rm = '0;
    rpu_bu_req_buf_vld = 1'b0;
    rpu_bu_req_buf_header_size = '0;
    rpu_bu_req_buf_data_size = '0;
    retire_burr_keep = 1'b0;

    idle(2);
    check_val("rst_rdy", 64'(brr_bu_rdy), 1);
    check_val("rst_retire_vld", 64'(burr_retire_vld), 0);
    check_val("rst_retire_fields", ret_obs(), 0);
    check_val("rst_gnt_vld", 64'(bu_rpu_gnt_buf_vld), 0);
    check_val("rst_gnt_fields", gnt_obs(), 0);
    rstn = 1'b1;
    idle(1);

    // Sixteen back-to-back successful allocations, then exhaustion.
    for (int k = 0; k < 16; k++)
      rpu_req(4096, gnt_exp(NOU_STATUS_OK, 0, 'h500 + 2 * k, 'h520 + (15 - k) * 32));
    rpu_req(4096, gnt_exp(NOU_STATUS_ERR, 1, 0, 0));
    idle(3);

    brr_cmd(BU_OP_RELEASE, 31, 0, 0, 0);
    brr_cmd(BU_OP_REVOKE, 31, 0, 0, 0);
    brr_cmd(BU_OP_REVOKE, 31, 0, 0, 2);
    brr_cmd(BU_OP_GRANT, 40, 'h900, 8, 3);
    idle(3);

    // Retire backpressure: four responses fill the queue, fifth waits.
    retire_burr_keep = 1'b1;
    brr_cmd(BU_OP_GRANT, 31, 'h1234, 8, 0);
    brr_cmd(BU_OP_REVOKE, 30, 0, 0, 2);
    brr_cmd(2'd3, 5, 0, 0, 4);
    brr_cmd(BU_OP_RELEASE, 0, 0, 0, 0);
    check_val("rdy_when_full", 64'(brr_bu_rdy), 0);
    check_val("retire_vld_held", 64'(burr_retire_vld), 1);
    fork
      brr_cmd(BU_OP_RELEASE, 0, 0, 0, 2);
      begin
        idle(3);
        retire_burr_keep = 1'b0;
      end
    join
    idle(6);

    // Same-cycle RPU allocation of slot 0 and REVOKE of slot 0.
    fork
      rpu_req(4096, gnt_exp(NOU_STATUS_OK, 0, 'h500, 'h1234));
      brr_cmd(BU_OP_REVOKE, 0, 0, 0, 2);
    join
    brr_cmd(BU_OP_RELEASE, 0, 0, 0, 0);
    idle(3);

    // Asynchronous reset with three responses queued.
    retire_burr_keep = 1'b1;
    brr_cmd(BU_OP_GRANT, 40, 0, 4, 3);
    brr_cmd(BU_OP_GRANT, 41, 0, 4, 3);
    brr_cmd(BU_OP_GRANT, 42, 0, 4, 3);
    check_val("retire_vld_before_rst", 64'(burr_retire_vld), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_val("async_rst_retire_vld", 64'(burr_retire_vld), 0);
    check_val("async_rst_rdy", 64'(brr_bu_rdy), 1);
    check_val("async_rst_retire_fields", ret_obs(), 0);
    ret_q.delete();
    gnt_q.delete();
    idle(2);
    rstn = 1'b1;
    retire_burr_keep = 1'b0;
    idle(2);

    n = 0;
    while ((gnt_q.size() != 0 || ret_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    check_val("scoreboard_drain", 64'(gnt_q.size() + ret_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
